// File: rtl/fxp2float_rne_pipe.sv
// fxp2float_rne_pipe: 3-stage Qm.n fixed-point to float32 converter with ready/valid flow control.
// Ports: clk, rstn (async active-low); fxp_in/valid_in/ready_in upstream; fp_out/valid_out/ready_out downstream.
module fxp2float_rne_pipe #(
  parameter int N      = 16,
  parameter int FRAC   = 8,
  parameter int SIGNED = 1,
  parameter int ROUND  = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] fxp_in,
  input  logic         valid_in,
  output logic         ready_in,
  output logic [31:0]  fp_out,
  output logic         valid_out,
  input  logic         ready_out
);
  if (N < 2 || N > 32 || FRAC < 0 || FRAC > N || SIGNED < 0 || SIGNED > 1 || ROUND < 0 || ROUND > 1) begin : g_param_err
    $error("fxp2float_rne_pipe: parameter out of legal range");
  end
  logic         en;
  logic         sign_in;
  logic         s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  logic [N-1:0] s1_abs_q, s1_abs_d;
  logic         s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
  logic [N-1:0] s2_abs_q, s2_abs_d;
  logic [4:0]   s2_msb_q, s2_msb_d;
  logic         valid_out_q, valid_out_d;
  logic [31:0]  fp_out_q, fp_out_d;
  logic [4:0]   msb, lsh, rsh;
  logic [31:0]  a;
  logic         big, g_bit, s_bit, l_bit, inc;
  logic [22:0]  mant_sh;
  logic [23:0]  mant_rnd;
  logic [7:0]   exp_w;
  always_comb begin
    en       = ready_out | ~valid_out_q;
    sign_in  = (SIGNED != 0) & fxp_in[N-1];
    msb      = '0;
    for (int i = 0; i < N; i++) if (s1_abs_q[i]) msb = 5'(i);
    a        = 32'(s2_abs_q);
    big      = s2_msb_q > 5'd23;
    lsh      = 5'd23 - s2_msb_q;
    rsh      = s2_msb_q - 5'd23;
    // guard, sticky and lsb of the kept field; only meaningful when big
    g_bit    = a[rsh - 5'd1];
    s_bit    = |(a & ((32'd1 << (rsh - 5'd1)) - 32'd1));
    l_bit    = a[rsh];
    inc      = (ROUND != 0) & big & g_bit & (s_bit | l_bit);
    mant_sh  = big ? 23'(a >> rsh) : 23'(a << lsh);
    mant_rnd = {1'b0, mant_sh} + 24'(inc);
    // bit 23 of mant_rnd is the rounding carry out of the mantissa
    exp_w    = 8'd127 + 8'(s2_msb_q) - 8'(FRAC) + 8'(mant_rnd[23]);
    s1_valid_d  = en ? valid_in : s1_valid_q;
    s1_sign_d   = en ? sign_in : s1_sign_q;
    s1_abs_d    = en ? (sign_in ? '0 - fxp_in : fxp_in) : s1_abs_q;
    s2_valid_d  = en ? s1_valid_q : s2_valid_q;
    s2_sign_d   = en ? s1_sign_q : s2_sign_q;
    s2_abs_d    = en ? s1_abs_q : s2_abs_q;
    s2_msb_d    = en ? msb : s2_msb_q;
    s2_zero_d   = en ? (s1_abs_q == '0) : s2_zero_q;
    valid_out_d = en ? s2_valid_q : valid_out_q;
    fp_out_d    = en ? (s2_zero_q ? 32'd0 : {s2_sign_q, exp_w, mant_rnd[22:0]}) : fp_out_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_abs_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_abs_q    <= '0;
      s2_msb_q    <= '0;
      s2_zero_q   <= 1'b0;
      valid_out_q <= 1'b0;
      fp_out_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_abs_q    <= s1_abs_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_abs_q    <= s2_abs_d;
      s2_msb_q    <= s2_msb_d;
      s2_zero_q   <= s2_zero_d;
      valid_out_q <= valid_out_d;
      fp_out_q    <= fp_out_d;
    end
  end
  assign ready_in  = en;
  assign valid_out = valid_out_q;
  assign fp_out    = fp_out_q;
endmodule
